// File: rtl/scpu_loader_pkg.sv
// Shared types and defaults for the program loader: FSM state encoding,
// error codes and the frame/timeout constants.
package scpu_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CHK  = 2'b01,
    ERR_TMO  = 2'b10
  } err_e;

  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd50000;

  // A LEN byte of zero encodes a full 256-byte payload.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/scpu_loader_tmo.sv
// Inter-byte idle counter: counts cycles while enabled, clears on every
// accepted byte, and flags expiry on the TIMEOUT_CYC-th consecutive idle cycle.
module scpu_loader_tmo #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [15:0] cnt_q, cnt_d;

  // A byte arriving in the expiring cycle wins, so clr_i masks expiry.
  assign expire_o = en_i && !clr_i && (cnt_q == (TIMEOUT_CYC - 16'd1));

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!en_i || clr_i || expire_o) begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scpu_loader.sv
// Program loader: parses SYNC/ADDR/LEN/DATA/CHK frames from the host link,
// writes payload into the shared RAM and releases the CPU on a good checksum.
module scpu_loader
  import scpu_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_valid_i,
  input  logic [7:0] host_data_i,
  output logic       host_ready_o,
  output logic       ld_mem_wr_o,
  output logic [7:0] ld_mem_addr_o,
  output logic [7:0] ld_mem_din_o,
  output logic       ld_cpu_rst_n_o,
  output logic       ld_busy_o,
  output logic       ld_done_o,
  output logic       ld_err_o,
  output logic [1:0] ld_err_code_o
);

  state_e     state_q;
  logic [7:0] ptr_q;
  logic [8:0] cnt_q;
  logic [7:0] sum_q;
  logic       mem_wr_q;
  logic [7:0] mem_addr_q;
  logic [7:0] mem_din_q;
  logic       cpu_rst_n_q;
  logic       done_q;
  logic       err_q;
  err_e       err_code_q;

  logic       accept;
  logic       tmo_expire;
  logic [7:0] chk_sum;

  assign host_ready_o = 1'b1;
  assign accept       = host_valid_i & host_ready_o;
  assign chk_sum      = sum_q + host_data_i;

  scpu_loader_tmo #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (accept),
    .en_i    (state_q != ST_IDLE),
    .expire_o(tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 8'd0;
      cnt_q       <= 9'd0;
      sum_q       <= 8'd0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_din_q   <= 8'd0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && (host_data_i == SYNC_BYTE)) begin
            state_q     <= ST_ADDR;
            cpu_rst_n_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            sum_q       <= 8'd0;
          end
        end
        ST_ADDR: begin
          if (accept) begin
            ptr_q   <= host_data_i;
            sum_q   <= chk_sum;
            state_q <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (accept) begin
            cnt_q   <= len_to_count(host_data_i);
            sum_q   <= chk_sum;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= ptr_q;
            mem_din_q  <= host_data_i;
            ptr_q      <= ptr_q + 8'd1;
            cnt_q      <= cnt_q - 9'd1;
            sum_q      <= chk_sum;
            if (cnt_q == 9'd1) begin
              state_q <= ST_CHK;
            end
          end
        end
        ST_CHK: begin
          if (accept) begin
            state_q <= ST_IDLE;
            if (chk_sum == 8'd0) begin
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CHK;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Expiry only fires in a cycle with no accepted byte, so it never
      // collides with the case branches above.
      if (tmo_expire) begin
        state_q    <= ST_IDLE;
        err_q      <= 1'b1;
        err_code_q <= ERR_TMO;
      end
    end
  end

  assign ld_mem_wr_o    = mem_wr_q;
  assign ld_mem_addr_o  = mem_addr_q;
  assign ld_mem_din_o   = mem_din_q;
  assign ld_cpu_rst_n_o = cpu_rst_n_q;
  assign ld_busy_o      = (state_q != ST_IDLE);
  assign ld_done_o      = done_q;
  assign ld_err_o       = err_q;
  assign ld_err_code_o  = err_code_q;

endmodule

// File: tb/tb_scpu_loader.sv
// Scoreboard bench for scpu_loader: frames are built and judged by a byte-level
// model; a negedge monitor matches RAM writes, done pulses and error events.
module tb_scpu_loader;

  localparam logic [15:0] TMO = 16'd8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic       ld_mem_wr;
  logic [7:0] ld_mem_addr;
  logic [7:0] ld_mem_din;
  logic       ld_cpu_rst_n;
  logic       ld_busy;
  logic       ld_done;
  logic       ld_err;
  logic [1:0] ld_err_code;

  always #5 clk = ~clk;

  scpu_loader #(
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_valid_i  (host_valid),
    .host_data_i   (host_data),
    .host_ready_o  (host_ready),
    .ld_mem_wr_o   (ld_mem_wr),
    .ld_mem_addr_o (ld_mem_addr),
    .ld_mem_din_o  (ld_mem_din),
    .ld_cpu_rst_n_o(ld_cpu_rst_n),
    .ld_busy_o     (ld_busy),
    .ld_done_o     (ld_done),
    .ld_err_o      (ld_err),
    .ld_err_code_o (ld_err_code)
  );

  // kind: 0 = RAM write, 1 = done pulse, 2 = error rising; cyc = acceptance cycle (-1: untimed)
  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       cpu_model = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] fdata[256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d,
                      input logic [1:0] code, input int c);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.code = code; e.cyc = c;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ld_mem_wr) begin
      if (expq.size() == 0 || expq[0].kind != 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, none expected", ld_mem_addr, ld_mem_din);
      end else begin
        e = expq.pop_front();
        check("wr_addr", ld_mem_addr, e.addr);
        check("wr_data", ld_mem_din, e.data);
        check("wr_latency", cyc, e.cyc + 1);
      end
    end
    if (ld_done) begin
      if (expq.size() == 0 || expq[0].kind != 1) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1, none expected");
      end else begin
        e = expq.pop_front();
        check("done_cpu_rst_n", ld_cpu_rst_n, 1);
        check("done_latency", cyc, e.cyc + 1);
      end
    end
    if (ld_err && !prev_err) begin
      if (expq.size() == 0 || expq[0].kind != 2) begin
        checks++; errors++;
        $display("FAIL unexpected_err: got err code %0h, none expected", ld_err_code);
      end else begin
        e = expq.pop_front();
        check("err_code_evt", ld_err_code, e.code);
        if (e.cyc >= 0) check("err_latency", cyc, e.cyc + 1);
      end
    end
    prev_err = ld_err;
  end

  task automatic send_byte(input logic [7:0] b);
    host_valid = 1'b1;
    host_data  = b;
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    host_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    host_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", host_ready, 1);
    check("rst_wr", ld_mem_wr, 0);
    check("rst_addr", ld_mem_addr, 0);
    check("rst_din", ld_mem_din, 0);
    check("rst_cpu_rst_n", ld_cpu_rst_n, 0);
    check("rst_busy", ld_busy, 0);
    check("rst_done", ld_done, 0);
    check("rst_err", ld_err, 0);
    check("rst_err_code", ld_err_code, 0);
  endtask

  // Sends a full frame from fdata; gap7_at forces a 7-cycle gap before that data index.
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] len, input logic [7:0] chk,
                            input int gap_max, input int gap7_at);
    int         n;
    logic [7:0] sum;
    n = (len == 8'd0) ? 256 : int'(len);
    send_byte(8'hA5);
    cpu_model = 1'b0;
    idle($urandom_range(0, gap_max));
    send_byte(addr);
    sum = addr;
    idle($urandom_range(0, gap_max));
    send_byte(len);
    sum = sum + len;
    for (int i = 0; i < n; i++) begin
      idle((i == gap7_at) ? 7 : $urandom_range(0, gap_max));
      push(0, 8'(int'(addr) + i), fdata[i], 2'b00, cyc);
      send_byte(fdata[i]);
      sum = sum + fdata[i];
      check("busy_in_frame", ld_busy, 1);
    end
    idle($urandom_range(0, gap_max));
    sum = sum + chk;
    if (sum == 8'd0) begin
      push(1, 8'd0, 8'd0, 2'b00, cyc);
      cpu_model = 1'b1;
    end else begin
      push(2, 8'd0, 8'd0, 2'b01, cyc);
    end
    send_byte(chk);
    idle(2);
    check("cpu_rst_n_after", ld_cpu_rst_n, cpu_model);
    check("busy_after", ld_busy, 0);
    check("err_after", ld_err, (sum != 8'd0));
    check("err_code_after", ld_err_code, (sum != 8'd0) ? 2'b01 : 2'b00);
  endtask

  function automatic logic [7:0] good_chk(input logic [7:0] addr, input logic [7:0] len);
    int n;
    int s;
    n = (len == 8'd0) ? 256 : int'(len);
    s = int'(addr) + int'(len);
    for (int i = 0; i < n; i++) s += int'(fdata[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b);
      check("junk_idle", ld_busy, 0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    host_valid = 1'b0;
    host_data  = 8'h00;
    idle(3);
    check_reset_outputs();
    rst_n = 1'b1;
    idle(2);

    // Good frame from the plan, back-to-back bytes
    fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33;
    send_frame(8'h10, 8'h03, 8'h87, 0, -1);
    // Same frame with a bad checksum, then recover
    send_frame(8'h10, 8'h03, 8'h00, 0, -1);
    send_frame(8'h10, 8'h03, 8'h87, 1, -1);

    // Address wrap, plus a 7-cycle gap that must not time out
    fdata[0] = 8'hA5; fdata[1] = 8'h01; fdata[2] = 8'h02;
    send_frame(8'hFE, 8'h03, good_chk(8'hFE, 8'h03), 1, 1);

    // LEN=0 means 256 bytes
    for (int i = 0; i < 256; i++) fdata[i] = 8'($urandom);
    send_frame(8'h40, 8'h00, good_chk(8'h40, 8'h00), 1, -1);

    // Timeout after ADDR: no error at 7 idle cycles, error at the 8th
    send_byte(8'hA5);
    cpu_model = 1'b0;
    send_byte(8'h20);
    push(2, 8'd0, 8'd0, 2'b10, -1);
    idle(7);
    check("tmo_not_yet", ld_err, 0);
    check("tmo_busy_pre", ld_busy, 1);
    idle(1);
    check("tmo_err", ld_err, 1);
    check("tmo_code", ld_err_code, 2'b10);
    check("tmo_idle", ld_busy, 0);
    check("tmo_cpu", ld_cpu_rst_n, 0);
    idle(3);

    // Timeout in DATA keeps the bytes already written
    send_byte(8'hA5);
    send_byte(8'h30);
    send_byte(8'h04);
    push(0, 8'h30, 8'hC1, 2'b00, cyc);
    send_byte(8'hC1);
    push(0, 8'h31, 8'hC2, 2'b00, cyc);
    send_byte(8'hC2);
    push(2, 8'd0, 8'd0, 2'b10, -1);
    idle(TMO + 2);
    check("tmo_data_code", ld_err_code, 2'b10);

    // Good load, then reset mid-frame after the 2nd data byte of a LEN=5 frame
    for (int i = 0; i < 4; i++) fdata[i] = 8'($urandom);
    send_frame(8'h80, 8'h04, good_chk(8'h80, 8'h04), 2, -1);
    send_byte(8'hA5);
    send_byte(8'h50);
    send_byte(8'h05);
    push(0, 8'h50, 8'h01, 2'b00, cyc);
    send_byte(8'h01);
    push(0, 8'h51, 8'h02, 2'b00, cyc);
    send_byte(8'h02);
    idle(1);
    rst_n = 1'b0;
    cpu_model = 1'b0;
    #1;
    check_reset_outputs();
    host_valid = 1'b1;
    host_data  = 8'h03;
    idle(2);
    check_reset_outputs();
    #2;
    rst_n = 1'b1;
    idle(1);
    send_junk(6);
    check("junk_cpu_held", ld_cpu_rst_n, 0);
    for (int i = 0; i < 5; i++) fdata[i] = 8'($urandom);
    send_frame(8'h50, 8'h05, good_chk(8'h50, 8'h05), 2, -1);

    // Randomized frames, about a quarter with a corrupted checksum
    for (int f = 0; f < 30; f++) begin
      logic [7:0] a, l, c;
      a = 8'($urandom);
      l = 8'($urandom_range(1, 40));
      for (int i = 0; i < int'(l); i++) fdata[i] = 8'($urandom);
      c = good_chk(a, l);
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      send_junk($urandom_range(0, 2));
      send_frame(a, l, c, 3, -1);
    end

    idle(5);
    check("scoreboard_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
